// File: rtl/uart_echo_pkg.sv
// Shared constants and helpers for the UART echo buffer.
// Used by the top level and by the ring store.
package uart_echo_pkg;

    localparam int         OVF_W       = 8;
    localparam logic [7:0] DEFAULT_EOL = 8'h0D;

    // Width of a counter that can hold the values 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/echo_ring.sv
// Circular store with independent read/write pointers, an occupancy count, and registered read data.
// o_head exposes the oldest entry combinationally so the caller can inspect the next byte before popping it.
module echo_ring
    import uart_echo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [DATA_W-1:0]         i_wr_data,
    output logic [DATA_W-1:0]         o_rd_data,
    output logic [DATA_W-1:0]         o_head,
    output logic [lvl_w(DEPTH)-1:0]   o_level,
    output logic [lvl_w(DEPTH)-1:0]   o_level_next,
    output logic                      o_full,
    output logic                      o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_push;
    logic              w_pop;
    logic [LVL_W-1:0]  w_level_next;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);

    // A write into a full ring is legal only when the oldest entry leaves in the same cycle.
    assign w_pop        = i_pop && !o_empty;
    assign w_push       = i_push && (!o_full || w_pop);
    assign w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

    // NOTE: the data array has no reset; stale contents are unreachable because the pointers and level are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: non-blocking assignments let a simultaneous push and pop on the same slot read the old entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_level <= w_level_next;
        end
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_rd_data    = r_rd_data;
    assign o_level      = r_level;
    assign o_level_next = w_level_next;

endmodule

// File: rtl/uart_echo_buffer.sv
// RX-to-TX loopback buffer with an optional line-buffered release, overflow accounting and fill status.
// It decides when bytes leave the ring and keeps at most one TX request outstanding.
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter int                AFULL_TH = 12,
    parameter logic [DATA_W-1:0] EOL      = DATA_W'(DEFAULT_EOL)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rx_valid,
    input  logic [DATA_W-1:0]         rx_byte,
    input  logic                      line_mode,
    input  logic                      ovf_clr,
    input  logic                      tx_busy,
    output logic                      tx_req,
    output logic [DATA_W-1:0]         tx_byte,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      almost_full,
    output logic                      overflow,
    output logic [OVF_W-1:0]          ovf_cnt
);

    localparam int               LVL_W   = lvl_w(DEPTH);
    localparam logic [OVF_W-1:0] CNT_MAX = '1;

    logic              r_tx_req;
    logic              r_almost_full;
    logic              r_overflow;
    logic [OVF_W-1:0]  r_ovf_cnt;
    logic [LVL_W-1:0]  r_line_cnt;
    logic              r_force_drain;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [LVL_W-1:0]  w_level_next;
    logic              w_release;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_push_eol;
    logic              w_pop_eol;

    // r_tx_req blocks the cycle after a request, before the UART has had time to raise tx_busy.
    assign w_release  = !w_empty && (!line_mode || (r_line_cnt != '0) || r_force_drain);
    assign w_pop      = w_release && !tx_busy && !r_tx_req;
    assign w_drop     = rx_valid && w_full && !w_pop;
    assign w_push     = rx_valid && !w_drop;
    assign w_push_eol = w_push && (rx_byte == EOL);
    assign w_pop_eol  = w_pop && (w_head == EOL);

    echo_ring #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_wr_data    (rx_byte),
        .o_rd_data    (tx_byte),
        .o_head       (w_head),
        .o_level      (level),
        .o_level_next (w_level_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_req      <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            r_tx_req      <= w_pop;
            r_almost_full <= (w_level_next >= LVL_W'(AFULL_TH));
        end
    end

    // Terminators held in the ring; a line is releasable while at least one is present.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_cnt <= '0;
        end else begin
            case ({w_push_eol, w_pop_eol})
                2'b10:   r_line_cnt <= r_line_cnt + LVL_W'(1);
                2'b01:   r_line_cnt <= r_line_cnt - LVL_W'(1);
                default: r_line_cnt <= r_line_cnt;
            endcase
        end
    end

    // A full ring with no terminator would never drain in line mode, so flush it once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_force_drain <= 1'b0;
        end else if (w_empty) begin
            r_force_drain <= 1'b0;
        end else if (line_mode && w_full && (r_line_cnt == '0)) begin
            r_force_drain <= 1'b1;
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr) begin
                r_ovf_cnt <= OVF_W'(1);
            end else if (r_ovf_cnt != CNT_MAX) begin
                r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
            end
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end
    end

    assign tx_req      = r_tx_req;
    assign almost_full = r_almost_full;
    assign overflow    = r_overflow;
    assign ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: echo latency, line hold, overflow, forced drain, wrap and reset.
// Stimulus and sampling happen on the falling edge; the DUT acts on the rising edge.
module tb_uart_echo_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              rx_valid  = 1'b0;
    logic [DATA_W-1:0] rx_byte   = '0;
    logic              line_mode = 1'b0;
    logic              ovf_clr   = 1'b0;
    logic              tx_busy;
    logic              tx_req;
    logic [DATA_W-1:0] tx_byte;
    logic [LVL_W-1:0]  level;
    logic              almost_full;
    logic              overflow;
    logic [7:0]        ovf_cnt;

    logic hold_busy = 1'b0;
    logic rnd_busy  = 1'b0;
    logic model_en  = 1'b0;
    logic m_busy;
    int   busy_cnt  = 0;

    int   checks  = 0;
    int   errors  = 0;
    int   req_cnt = 0;
    bit   b2b     = 1'b0;
    logic prev_req = 1'b0;
    bit   mon_en  = 1'b0;
    logic [7:0] txq [$];

    assign m_busy  = (busy_cnt > 0);
    assign tx_busy = hold_busy | rnd_busy | (model_en & m_busy);

    always #5 clk = ~clk;

    uart_echo_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (12),
        .EOL      (8'h0D)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .line_mode   (line_mode),
        .ovf_clr     (ovf_clr),
        .tx_busy     (tx_busy),
        .tx_req      (tx_req),
        .tx_byte     (tx_byte),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ovf_cnt     (ovf_cnt)
    );

    // Request monitor plus a simple UART model that stays busy for four cycles after each request.
    always @(negedge clk) begin
        prev_req <= tx_req;
        if (tx_req) begin
            req_cnt <= req_cnt + 1;
            if (prev_req) b2b <= 1'b1;
            if (mon_en) txq.push_back(tx_byte);
            busy_cnt <= 4;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req(input int budget, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!tx_req && n < budget);
        check({tag, "_req"}, 32'(tx_req), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sent;
        int cyc;
        int full_push;
        int mism;

        // Reset state
        repeat (3) step();
        check("rst_tx_req", 32'(tx_req), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        reset_n  = 1'b1;
        model_en = 1'b1;
        step();

        // Echo mode: two bytes, request two cycles after the first strobe
        rx_valid = 1'b1;
        rx_byte  = 8'h41;
        step();
        rx_byte = 8'h42;
        check("echo_n1_req", 32'(tx_req), 32'd0);
        check("echo_n1_level", 32'(level), 32'd1);
        step();
        rx_valid = 1'b0;
        check("echo_n2_req", 32'(tx_req), 32'd1);
        check("echo_n2_byte", 32'(tx_byte), 32'h41);
        check("echo_n2_level", 32'(level), 32'd1);
        wait_req(20, "echo_b");
        check("echo_b_byte", 32'(tx_byte), 32'h42);
        repeat (3) step();
        check("echo_empty", 32'(level), 32'd0);

        // Line mode: "ab" held until the terminator arrives
        line_mode = 1'b1;
        step();
        rx_valid = 1'b1;
        rx_byte  = 8'h61;
        step();
        rx_byte = 8'h62;
        step();
        rx_valid = 1'b0;
        base = req_cnt;
        repeat (100) step();
        check("line_hold_reqs", 32'(req_cnt - base), 32'd0);
        check("line_hold_level", 32'(level), 32'd2);
        rx_valid = 1'b1;
        rx_byte  = 8'h0D;
        step();
        rx_valid = 1'b0;
        wait_req(20, "line_a");
        check("line_a_byte", 32'(tx_byte), 32'h61);
        wait_req(20, "line_b");
        check("line_b_byte", 32'(tx_byte), 32'h62);
        wait_req(20, "line_eol");
        check("line_eol_byte", 32'(tx_byte), 32'h0D);
        repeat (3) step();
        check("line_cnt_zero", 32'(dut.r_line_cnt), 32'd0);
        check("line_empty", 32'(level), 32'd0);

        // Overflow: 20 pushes into a stalled 16-entry buffer
        line_mode = 1'b0;
        hold_busy = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            rx_valid = 1'b1;
            rx_byte  = 8'(8'h80 + i);
            step();
            check($sformatf("ovf_level_%0d", i), 32'(level), 32'((i + 1 > 16) ? 16 : i + 1));
            if (i == 10) check("ovf_af_11", 32'(almost_full), 32'd0);
            if (i == 11) check("ovf_af_12", 32'(almost_full), 32'd1);
        end
        rx_valid = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_cnt_4", 32'(ovf_cnt), 32'd4);
        check("ovf_af_full", 32'(almost_full), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr_flag", 32'(overflow), 32'd0);
        check("ovf_clr_cnt", 32'(ovf_cnt), 32'd0);
        rx_valid = 1'b1;
        ovf_clr  = 1'b1;
        rx_byte  = 8'hEE;
        step();
        ovf_clr = 1'b0;
        check("ovf_drop_wins_flag", 32'(overflow), 32'd1);
        check("ovf_drop_wins_cnt", 32'(ovf_cnt), 32'd1);
        repeat (300) step();
        rx_valid = 1'b0;
        check("ovf_cnt_sat", 32'(ovf_cnt), 32'd255);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr2_cnt", 32'(ovf_cnt), 32'd0);
        hold_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_req(30, "ovf_drain");
            check($sformatf("ovf_drain_byte_%0d", i), 32'(tx_byte), 32'(8'h80 + i));
        end
        repeat (3) step();
        check("ovf_drain_level", 32'(level), 32'd0);
        check("ovf_drain_af", 32'(almost_full), 32'd0);

        // Forced drain: line mode, 16 bytes without a terminator
        line_mode = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1;
            rx_byte  = 8'(8'h30 + i);
            step();
        end
        rx_valid = 1'b0;
        check("fd_full_level", 32'(level), 32'd16);
        check("fd_no_req_yet", 32'(tx_req), 32'd0);
        step();
        check("fd_set", 32'(dut.r_force_drain), 32'd1);
        for (int i = 0; i < 16; i++) begin
            wait_req(30, "fd_drain");
            check($sformatf("fd_byte_%0d", i), 32'(tx_byte), 32'(8'h30 + i));
        end
        repeat (3) step();
        check("fd_clear", 32'(dut.r_force_drain), 32'd0);
        check("fd_empty", 32'(level), 32'd0);
        rx_valid = 1'b1;
        rx_byte  = 8'h55;
        step();
        rx_valid = 1'b0;
        base = req_cnt;
        repeat (30) step();
        check("fd_next_held", 32'(req_cnt - base), 32'd0);
        check("fd_next_level", 32'(level), 32'd1);
        line_mode = 1'b0;
        wait_req(20, "mode_switch");
        check("mode_switch_byte", 32'(tx_byte), 32'h55);
        repeat (8) step();

        // Wrap: 3*DEPTH bytes, random busy, pushes into a full ring only alongside a pop
        model_en = 1'b0;
        txq.delete();
        mon_en    = 1'b1;
        sent      = 0;
        cyc       = 0;
        full_push = 0;
        while (sent < 3 * DEPTH && cyc < 3000) begin
            rnd_busy = ($urandom_range(0, 3) != 0);
            if (level < LVL_W'(DEPTH) || (!tx_req && !rnd_busy)) begin
                rx_valid = 1'b1;
                rx_byte  = 8'(sent);
                if (level == LVL_W'(DEPTH)) full_push++;
                sent++;
            end else begin
                rx_valid = 1'b0;
            end
            step();
            cyc++;
        end
        rx_valid = 1'b0;
        rnd_busy = 1'b0;
        cyc = 0;
        while (txq.size() < 3 * DEPTH && cyc < 500) begin
            step();
            cyc++;
        end
        step();
        check("wrap_count", 32'(txq.size()), 32'(3 * DEPTH));
        mism = 0;
        for (int i = 0; i < txq.size(); i++) begin
            if (txq[i] !== 8'(i)) mism++;
        end
        check("wrap_order", 32'(mism), 32'd0);
        check("wrap_full_push_seen", 32'(full_push > 0), 32'd1);
        check("wrap_no_ovf", 32'(overflow), 32'd0);
        check("wrap_ovf_cnt", 32'(ovf_cnt), 32'd0);
        mon_en   = 1'b0;
        model_en = 1'b1;

        // Reset mid-stream with five bytes buffered
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_byte  = 8'(8'hA0 + i);
            step();
        end
        rx_valid = 1'b0;
        check("rst_mid_level_pre", 32'(level), 32'd5);
        reset_n = 1'b0;
        #1;
        check("rst_mid_tx_req", 32'(tx_req), 32'd0);
        check("rst_mid_level", 32'(level), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        check("rst_mid_tx_byte", 32'(tx_byte), 32'd0);
        step();
        reset_n   = 1'b1;
        hold_busy = 1'b0;
        step();
        check("rst_after_level", 32'(level), 32'd0);
        rx_valid = 1'b1;
        rx_byte  = 8'h77;
        step();
        rx_valid = 1'b0;
        check("rst_echo_n1_req", 32'(tx_req), 32'd0);
        step();
        check("rst_echo_n2_req", 32'(tx_req), 32'd1);
        check("rst_echo_byte", 32'(tx_byte), 32'h77);
        repeat (6) step();

        check("no_back_to_back_req", 32'(b2b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
